// File: rtl/atax_pkg.sv
// Shared sizes and FSM encoding for the Bambu ATAX board wrapper.
package atax_pkg;
   localparam int N       = 4;
   localparam int DW      = 16;
   localparam int YW      = 32;
   localparam int NIBBLES = YW / 4;
   localparam int IW      = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [2:0] {IDLE, TMP, YACC, OUT, DONE} state_t;
endpackage

// File: rtl/atax_wrapper_bambu_nibble_serializer.sv
// Shifts a YW-bit word out as YW/4 nibbles, least-significant first.
module nibble_serializer #(
   parameter int YW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [YW-1:0] word,
   output logic [3:0]    data_out,
   output logic          data_valid,
   output logic          busy
);
   localparam int NIB = YW / 4;
   localparam int CW  = $clog2(NIB + 1);

   logic [YW-1:0] shreg;
   logic [CW-1:0] remain;

   // The first nibble goes out on the load edge itself, so a load right after
   // the last nibble gives a gapless stream.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg      <= '0;
         remain     <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (load) begin
         data_out   <= word[3:0];
         data_valid <= 1'b1;
         shreg      <= word >> 4;
         remain     <= CW'(NIB - 1);
      end else if (remain != '0) begin
         data_out   <= shreg[3:0];
         data_valid <= 1'b1;
         shreg      <= shreg >> 4;
         remain     <= remain - 1'b1;
      end else begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end
   end

   // High while more nibbles follow the one currently on data_out.
   assign busy = data_valid && (remain != '0);
endmodule

// File: rtl/atax_wrapper_bambu.sv
// ATAX (y = A^T * A * x) board wrapper: on-chip A/x generation, one run per
// reset, results streamed out as nibbles.
module atax_wrapper_bambu
   import atax_pkg::*;
#(
   parameter int N  = atax_pkg::N,
   parameter int DW = atax_pkg::DW,
   parameter int YW = atax_pkg::YW
) (
   input  logic       clk_p,
   input  logic       clk_n,
   input  logic       ap_rst,
   output logic       probe_out,
   output logic [3:0] data_out,
   output logic       data_valid
);
   localparam int IW  = (N > 1) ? $clog2(N) : 1;
   localparam int WCW = $clog2(N + 1);

   logic ap_clk;
   logic unused_clk_n;
   assign ap_clk       = clk_p;
   assign unused_clk_n = clk_n;

   state_t              state, state_nx;
   logic [IW-1:0]       i, j;
   logic [WCW-1:0]      wcnt;
   logic [N-1:0][YW-1:0] tmp, y;

   logic          last_ij, words_done, ser_busy;
   logic          y_out_write;
   logic [YW-1:0] y_out_din;
   logic [DW-1:0] a_ij, x_j;
   logic [YW-1:0] mul_a, mul_b, acc_in, mac;

   assign last_ij = (i == IW'(N - 1)) && (j == IW'(N - 1));
   assign a_ij    = DW'(i) + DW'(j) + DW'(1);
   assign x_j     = DW'(j) + DW'(1);

   // One MAC shared by both passes; only the operand routing changes.
   assign mul_a  = YW'(a_ij);
   assign mul_b  = (state == YACC) ? tmp[i] : YW'(x_j);
   assign acc_in = (state == YACC) ? y[j] : tmp[i];
   assign mac    = acc_in + mul_a * mul_b;

   assign words_done  = (wcnt == WCW'(N));
   assign y_out_write = (state == OUT) && !data_valid && !words_done;
   assign y_out_din   = y[wcnt[IW-1:0]];

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: state_nx = TMP;
         TMP:  if (last_ij) state_nx = YACC;
         YACC: if (last_ij) state_nx = OUT;
         OUT:  if (words_done && data_valid && !ser_busy) state_nx = DONE;
         DONE: state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state     <= IDLE;
         i         <= '0;
         j         <= '0;
         wcnt      <= '0;
         tmp       <= '0;
         y         <= '0;
         probe_out <= 1'b0;
      end else begin
         state     <= state_nx;
         probe_out <= probe_out || (state_nx == DONE);
         case (state)
            IDLE: begin
               tmp  <= '0;
               y    <= '0;
               i    <= '0;
               j    <= '0;
               wcnt <= '0;
            end
            TMP, YACC: begin
               if (state == TMP) tmp[i] <= mac;
               else              y[j]   <= mac;
               if (last_ij) begin
                  i <= '0;
                  j <= '0;
               end else if (j == IW'(N - 1)) begin
                  i <= i + 1'b1;
                  j <= '0;
               end else begin
                  j <= j + 1'b1;
               end
            end
            OUT: if (y_out_write) wcnt <= wcnt + 1'b1;
            default: ;
         endcase
      end
   end

   nibble_serializer #(.YW(YW)) u_ser (
      .clk        (ap_clk),
      .rst        (ap_rst),
      .load       (y_out_write),
      .word       (y_out_din),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (ser_busy)
   );
endmodule

// File: tb/tb_atax_wrapper_bambu.sv
// Bench for atax_wrapper_bambu: per-cycle comparison against a formula model.
`timescale 1ns/1ps
module tb_atax_wrapper_bambu;
   localparam int N        = 4;
   localparam int YW       = 32;
   localparam int NIB      = YW / 4;
   localparam int WORD_CYC = NIB + 1;
   localparam int FIRST_WR = 2 * N * N + 2;
   localparam int DONE_C   = FIRST_WR + N * WORD_CYC;

   logic       clk_p = 1'b0;
   logic       clk_n;
   logic       ap_rst = 1'b1;
   logic       probe_out, data_valid;
   logic [3:0] data_out;

   int n_assert = 0;
   int n_fail   = 0;

   logic [YW-1:0] ymodel [N];
   logic [YW-1:0] spec_words [N];

   always #1.667 clk_p = ~clk_p;
   assign clk_n = ~clk_p;

   atax_wrapper_bambu dut (
      .clk_p      (clk_p),
      .clk_n      (clk_n),
      .ap_rst     (ap_rst),
      .probe_out  (probe_out),
      .data_out   (data_out),
      .data_valid (data_valid)
   );

   task automatic chk(input string tag, input logic [YW-1:0] obs, input logic [YW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // y = A^T (A x) with A[i][j]=i+j+1, x[j]=j+1, all modulo 2^YW.
   task automatic build_model();
      logic [YW-1:0] t [N];
      for (int r = 0; r < N; r++) begin
         t[r] = '0;
         for (int c = 0; c < N; c++) t[r] = t[r] + YW'((r + c + 1) * (c + 1));
      end
      for (int c = 0; c < N; c++) begin
         ymodel[c] = '0;
         for (int r = 0; r < N; r++) ymodel[c] = ymodel[c] + YW'(r + c + 1) * t[r];
      end
   endtask

   // Checks cycles 1..last_c after a release; cycle 1 is sampled at the next negedge.
   task automatic run_check(input int last_c);
      logic [YW-1:0] cap;
      cap = '0;
      for (int c = 1; c <= last_c; c++) begin
         int rel, w, p;
         logic exp_wr, exp_dv;
         logic [3:0] exp_nib;
         @(negedge clk_p);
         rel = c - FIRST_WR;
         exp_wr = 1'b0; exp_dv = 1'b0; exp_nib = 4'h0; w = 0; p = 0;
         if (rel >= 0 && rel < N * WORD_CYC) begin
            w = rel / WORD_CYC;
            p = rel % WORD_CYC;
            exp_wr = (p == 0);
            exp_dv = (p != 0);
            if (exp_dv) exp_nib = ymodel[w][4*(p-1) +: 4];
         end
         chk("y_out_write", YW'(dut.y_out_write), YW'(exp_wr));
         if (exp_wr) begin
            chk("y_out_din_model", dut.y_out_din, ymodel[w]);
            chk("y_out_din_table", dut.y_out_din, spec_words[w]);
         end
         chk("data_valid", YW'(data_valid), YW'(exp_dv));
         chk("data_out", YW'(data_out), YW'(exp_nib));
         chk("probe_out", YW'(probe_out), YW'(c >= DONE_C));
         if (exp_dv) begin
            cap[4*(p-1) +: 4] = data_out;
            if (p == NIB) chk("nibble_concat", cap, ymodel[w]);
         end
      end
   endtask

   task automatic hold_reset_check(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk_p);
         chk("rst_data_valid", YW'(data_valid), '0);
         chk("rst_data_out", YW'(data_out), '0);
         chk("rst_probe_out", YW'(probe_out), '0);
         chk("rst_y_out_write", YW'(dut.y_out_write), '0);
      end
   endtask

   task automatic release_rst();
      @(posedge clk_p);
      #1 ap_rst = 1'b0;
   endtask

   // Raise reset between edges and confirm outputs clear with no clock edge.
   task automatic async_reset_check(input string tag);
      #0.3 ap_rst = 1'b1;
      #0.2;
      chk({tag, "_data_valid"}, YW'(data_valid), '0);
      chk({tag, "_data_out"}, YW'(data_out), '0);
      chk({tag, "_probe_out"}, YW'(probe_out), '0);
   endtask

   initial begin
      int k;
      spec_words[0] = 32'h1F4; spec_words[1] = 32'h2A8;
      spec_words[2] = 32'h35C; spec_words[3] = 32'h410;
      build_model();

      // Long reset (~100 ns), then a full run including 200+ idle cycles after done.
      hold_reset_check(30);
      @(posedge clk_p);
      #0.1 chk("ap_clk_follows_clk_p", YW'(dut.ap_clk), YW'(clk_p));
      release_rst();
      run_check(DONE_C + 210);

      // Reset with probe_out high, then reset during the second burst.
      async_reset_check("async_done");
      hold_reset_check(3);
      release_rst();
      k = $urandom_range(FIRST_WR + WORD_CYC + NIB, FIRST_WR + WORD_CYC + 1);
      run_check(k);
      chk("mid_burst_valid_before_rst", YW'(data_valid), 32'd1);
      async_reset_check("async_burst");
      hold_reset_check(3);
      release_rst();
      run_check(DONE_C + 20);

      // Reset at a random point in the compute phase, then a full repeat.
      async_reset_check("async_post");
      hold_reset_check(2);
      release_rst();
      k = $urandom_range(FIRST_WR - 1, 2);
      run_check(k);
      async_reset_check("async_compute");
      hold_reset_check(4);
      release_rst();
      run_check(DONE_C + 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
